// File: rtl/cond_exec_unit.sv
// Execute-stage condition evaluation: architectural NZCV register, ARM condition check,
// gated E->M control registers and executed/skipped instruction counters.
module cond_exec_unit #(
   parameter int unsigned CNTBITS = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ValidE,
   input  logic               StallE,
   input  logic               FlushE,
   input  logic [3:0]         CondE,
   input  logic [1:0]         FlagWriteE,
   input  logic [3:0]         ALUFlags,
   input  logic               PCSrcE,
   input  logic               RegWriteE,
   input  logic               MemWriteE,
   output logic               PCSrcM,
   output logic               RegWriteM,
   output logic               MemWriteM,
   output logic               CondExM,
   output logic [3:0]         Flags,
   output logic [CNTBITS-1:0] ExecCount,
   output logic [CNTBITS-1:0] SkipCount
);

   logic [3:0]         flags_q, flags_d;
   logic               pc_src_q, reg_write_q, mem_write_q, cond_ex_q;
   logic [CNTBITS-1:0] exec_cnt_q, skip_cnt_q;
   logic               cond_ex, live, fire;
   logic               n_flag, z_flag, c_flag, v_flag;

   assign {n_flag, z_flag, c_flag, v_flag} = flags_q;

   // Condition uses the registered flags only; ALUFlags is never bypassed in.
   always_comb begin
      cond_ex = 1'b0;
      unique case (CondE)
         4'b0000: cond_ex = z_flag;
         4'b0001: cond_ex = ~z_flag;
         4'b0010: cond_ex = c_flag;
         4'b0011: cond_ex = ~c_flag;
         4'b0100: cond_ex = n_flag;
         4'b0101: cond_ex = ~n_flag;
         4'b0110: cond_ex = v_flag;
         4'b0111: cond_ex = ~v_flag;
         4'b1000: cond_ex = c_flag & ~z_flag;
         4'b1001: cond_ex = ~c_flag | z_flag;
         4'b1010: cond_ex = (n_flag == v_flag);
         4'b1011: cond_ex = (n_flag != v_flag);
         4'b1100: cond_ex = ~z_flag & (n_flag == v_flag);
         4'b1101: cond_ex = z_flag | (n_flag != v_flag);
         4'b1110: cond_ex = 1'b1;
         4'b1111: cond_ex = 1'b0;
         default: cond_ex = 1'b0;
      endcase
   end

   assign live = ValidE & ~FlushE;
   assign fire = live & cond_ex;

   always_comb begin
      flags_d = flags_q;
      if (fire) begin
         if (FlagWriteE[1]) flags_d[3:2] = ALUFlags[3:2];
         if (FlagWriteE[0]) flags_d[1:0] = ALUFlags[1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q     <= 4'b0000;
         pc_src_q    <= 1'b0;
         reg_write_q <= 1'b0;
         mem_write_q <= 1'b0;
         cond_ex_q   <= 1'b0;
         exec_cnt_q  <= '0;
         skip_cnt_q  <= '0;
      end else if (!StallE) begin
         flags_q     <= flags_d;
         pc_src_q    <= PCSrcE & fire;
         reg_write_q <= RegWriteE & fire;
         mem_write_q <= MemWriteE & fire;
         cond_ex_q   <= fire;
         if (live) begin
            if (cond_ex) exec_cnt_q <= exec_cnt_q + 1'b1;
            else         skip_cnt_q <= skip_cnt_q + 1'b1;
         end
      end
   end

   assign Flags     = flags_q;
   assign PCSrcM    = pc_src_q;
   assign RegWriteM = reg_write_q;
   assign MemWriteM = mem_write_q;
   assign CondExM   = cond_ex_q;
   assign ExecCount = exec_cnt_q;
   assign SkipCount = skip_cnt_q;

endmodule
